// File: rtl/bcd_counter_ndigit.sv
// N-digit packed-BCD up/down counter with programmable bounds,
// validated synchronous load and a registered wrap pulse for cascading.
module bcd_counter_ndigit #(
  parameter int DIGITS = 4,
  parameter logic [4*DIGITS-1:0] RESET_VAL = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic [4*DIGITS-1:0] bcd_min,
  input  logic [4*DIGITS-1:0] bcd_max,
  output logic [4*DIGITS-1:0] count,
  output logic                wrap,
  output logic                load_err,
  output logic                cfg_err
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         wrap_q;
  logic         wrap_d;
  logic         lerr_q;
  logic         lerr_d;

  logic [W-1:0] inc_val;
  logic [W-1:0] dec_val;
  logic         digits_ok;
  logic         load_ok;
  logic         ge_max;
  logic         le_min;
  logic         gt_max;
  logic         do_load;
  logic         do_step;

  assign cfg_err = bcd_min > bcd_max;

  always_comb begin
    digits_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) begin
        digits_ok = 1'b0;
      end
    end
  end

  assign load_ok = digits_ok
                 && !cfg_err
                 && (load_val >= bcd_min)
                 && (load_val <= bcd_max);

  // Ripple carry; the carry out of the top digit is dropped
  // because the bound check always wins before it can matter.
  always_comb begin
    logic       c;
    logic [3:0] d;
    c       = 1'b1;
    inc_val = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d = count_q[4*i +: 4];
      if (c && d == 4'd9) begin
        inc_val[4*i +: 4] = 4'd0;
        c = 1'b1;
      end else begin
        inc_val[4*i +: 4] = d + {3'b000, c};
        c = 1'b0;
      end
    end
  end

  always_comb begin
    logic       b;
    logic [3:0] d;
    b       = 1'b1;
    dec_val = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d = count_q[4*i +: 4];
      if (b && d == 4'd0) begin
        dec_val[4*i +: 4] = 4'd9;
        b = 1'b1;
      end else begin
        dec_val[4*i +: 4] = d - {3'b000, b};
        b = 1'b0;
      end
    end
  end

  assign ge_max  = count_q >= bcd_max;
  assign le_min  = count_q <= bcd_min;
  assign gt_max  = count_q > bcd_max;
  assign do_load = load;
  assign do_step = !load && en && !cfg_err;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    lerr_d  = 1'b0;
    unique case (1'b1)
      do_load: begin
        if (load_ok) begin
          count_d = load_val;
        end else begin
          lerr_d = 1'b1;
        end
      end
      do_step && up: begin
        if (ge_max) begin
          count_d = bcd_min;
          wrap_d  = 1'b1;
        end else begin
          count_d = inc_val;
        end
      end
      do_step && !up: begin
        if (le_min) begin
          count_d = bcd_max;
          wrap_d  = 1'b1;
        end else if (gt_max) begin
          count_d = bcd_max;
        end else begin
          count_d = dec_val;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= RESET_VAL;
      wrap_q  <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      lerr_q  <= lerr_d;
    end
  end

  assign count    = count_q;
  assign wrap     = wrap_q;
  assign load_err = lerr_q;

endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// Directed plus randomized bench for bcd_counter_ndigit,
// checked against an integer-valued reference model.
module tb_bcd_counter_ndigit;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        up;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] bcd_min;
  logic [15:0] bcd_max;
  logic [15:0] count;
  logic        wrap;
  logic        load_err;
  logic        cfg_err;

  int vectors;
  int errors;
  int m_cnt;
  bit m_wrap;
  bit m_lerr;

  bcd_counter_ndigit #(
    .DIGITS(4),
    .RESET_VAL(16'h0000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .up(up),
    .load(load),
    .load_val(load_val),
    .bcd_min(bcd_min),
    .bcd_max(bcd_max),
    .count(count),
    .wrap(wrap),
    .load_err(load_err),
    .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int to_int(input logic [15:0] b);
    int v;
    v = 0;
    for (int i = 3; i >= 0; i--) begin
      v = v * 10 + int'(b[4*i +: 4]);
    end
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] b;
    int t;
    t = v;
    b = '0;
    for (int i = 0; i < 4; i++) begin
      b[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return b;
  endfunction

  function automatic bit is_bcd(input logic [15:0] b);
    for (int i = 0; i < 4; i++) begin
      if (b[4*i +: 4] > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    int lo;
    int hi;
    int lv;
    bit ok;
    lo = to_int(bcd_min);
    hi = to_int(bcd_max);
    lv = to_int(load_val);
    m_wrap = 1'b0;
    m_lerr = 1'b0;
    if (load) begin
      ok = is_bcd(load_val) && lo <= hi && lv >= lo && lv <= hi;
      if (ok) m_cnt = lv;
      else m_lerr = 1'b1;
    end else if (en && lo <= hi) begin
      if (up) begin
        if (m_cnt >= hi) begin
          m_cnt = lo;
          m_wrap = 1'b1;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end else begin
        if (m_cnt <= lo) begin
          m_cnt = hi;
          m_wrap = 1'b1;
        end else if (m_cnt > hi) begin
          m_cnt = hi;
        end else begin
          m_cnt = m_cnt - 1;
        end
      end
    end
    @(posedge clk);
    #1;
    check("count", count, to_bcd(m_cnt));
    check("wrap", {15'd0, wrap}, {15'd0, m_wrap});
    check("load_err", {15'd0, load_err}, {15'd0, m_lerr});
    check("cfg_err", {15'd0, cfg_err}, {15'd0, bit'(lo > hi)});
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1;
    load_val = v;
    cyc();
    load = 1'b0;
  endtask

  initial begin
    vectors  = 0;
    errors   = 0;
    m_cnt    = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    up       = 1'b1;
    load     = 1'b0;
    load_val = '0;
    bcd_min  = 16'h0000;
    bcd_max  = 16'h9999;

    @(posedge clk);
    #1;
    check("rst_count", count, 16'h0000);
    check("rst_wrap", {15'd0, wrap}, 16'h0000);
    check("rst_lerr", {15'd0, load_err}, 16'h0000);
    rst_n = 1'b1;

    // async reset mid-cycle while counting
    do_load(16'h0035);
    en = 1'b1;
    cyc();
    cyc();
    check("pre_rst", count, 16'h0037);
    #2;
    rst_n = 1'b0;
    #1;
    m_cnt = 0;
    check("async_rst", count, 16'h0000);
    check("async_wrap", {15'd0, wrap}, 16'h0000);
    check("async_lerr", {15'd0, load_err}, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    en = 1'b0;

    // seconds wrap
    bcd_max = 16'h0059;
    do_load(16'h0058);
    en = 1'b1;
    cyc();
    check("sec_59", count, 16'h0059);
    cyc();
    check("sec_wrap_cnt", count, 16'h0000);
    check("sec_wrap", {15'd0, wrap}, 16'h0001);
    cyc();
    check("sec_01", count, 16'h0001);
    check("sec_nowrap", {15'd0, wrap}, 16'h0000);
    en = 1'b0;

    // digit carry and borrow
    bcd_max = 16'h9999;
    do_load(16'h0199);
    en = 1'b1;
    cyc();
    check("carry", count, 16'h0200);
    en = 1'b0;
    do_load(16'h9999);
    en = 1'b1;
    cyc();
    check("top_wrap", count, 16'h0000);
    en = 1'b0;
    do_load(16'h1000);
    en = 1'b1;
    up = 1'b0;
    cyc();
    check("borrow", count, 16'h0999);
    en = 1'b0;

    // 12-hour style bounds
    bcd_min = 16'h0001;
    bcd_max = 16'h0012;
    do_load(16'h0010);
    en = 1'b1;
    cyc();
    check("hr_09", count, 16'h0009);
    en = 1'b0;
    do_load(16'h0001);
    en = 1'b1;
    cyc();
    check("hr_wrap", count, 16'h0012);
    en = 1'b0;
    do_load(16'h0009);
    bcd_max = 16'h0005;
    en = 1'b1;
    up = 1'b1;
    cyc();
    check("oor_up", count, 16'h0001);
    en = 1'b0;
    bcd_max = 16'h0012;
    do_load(16'h0009);
    bcd_max = 16'h0005;
    en = 1'b1;
    up = 1'b0;
    cyc();
    check("oor_dn", count, 16'h0005);
    en = 1'b0;

    // load validation
    bcd_min = 16'h0000;
    bcd_max = 16'h0059;
    do_load(16'h0A00);
    do_load(16'h0060);
    en = 1'b1;
    up = 1'b1;
    do_load(16'h0030);
    check("ld_no_step", count, 16'h0030);
    en = 1'b0;

    // inverted bounds
    bcd_min = 16'h0020;
    bcd_max = 16'h0010;
    en = 1'b1;
    cyc();
    cyc();
    do_load(16'h0015);
    en = 1'b0;

    // randomized traffic
    bcd_min = 16'h0000;
    bcd_max = 16'h0059;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        bcd_min = to_bcd($urandom_range(0, 60));
        bcd_max = to_bcd($urandom_range(0, 9999));
        if ($urandom_range(0, 3) == 0) bcd_max = to_bcd($urandom_range(0, 80));
        if ($urandom_range(0, 9) == 0) bcd_max = bcd_min;
      end
      load = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 4) == 0) load_val = 16'($urandom);
      else load_val = to_bcd($urandom_range(0, 120));
      en = ($urandom_range(0, 9) < 7);
      up = 1'($urandom);
      cyc();
    end
    load = 1'b0;
    en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
